// File: rtl/washing_machine.sv
// Washing machine program controller: IDLE->FILL->WASH->RINSE->SPIN->DRAIN->END.
// Optional door-open pause during a running program is enabled by defining WM_DOOR_PAUSE_EN.
module washing_machine #(
  parameter int MIN_PHASE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       door_closed,
  input  logic       water_level,
  input  logic       cycle_complete,
  output logic [2:0] state,
  output logic       motor_on,
  output logic       water_valve,
  output logic       drain_valve,
  output logic       buzzer
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FILL  = 3'b001,
    ST_WASH  = 3'b010,
    ST_RINSE = 3'b011,
    ST_SPIN  = 3'b100,
    ST_DRAIN = 3'b101,
    ST_END   = 3'b110
  } state_t;

  localparam int CNT_W = (MIN_PHASE_CYCLES < 2) ? 1 : $clog2(MIN_PHASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic             cc_q;
  logic             cc_edge;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_ok;
  logic             in_phase;
  logic             adv;
  logic             hold;

  assign cc_edge  = cycle_complete & ~cc_q;
  assign in_phase = (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN) || (st == ST_DRAIN);
  assign adv      = cc_edge & phase_ok;

  // With no minimum the count never gates a phase edge, so skip the compare entirely.
  generate
    if (MIN_PHASE_CYCLES == 0) begin : g_no_min
      assign phase_ok = 1'b1;
    end else begin : g_min
      localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PHASE_CYCLES);
      assign phase_ok = (phase_cnt >= MIN_CNT);
    end
  endgenerate

`ifdef WM_DOOR_PAUSE_EN
  logic paused;
  logic active;
  assign active = (st == ST_FILL) || in_phase;
  // The edge that opens or re-closes the door does not advance the program.
  assign hold   = paused | (active & ~door_closed);
`else
  assign hold   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= ST_IDLE;
      cc_q      <= 1'b0;
      phase_cnt <= '0;
`ifdef WM_DOOR_PAUSE_EN
      paused    <= 1'b0;
`endif
    end else begin
      cc_q <= cycle_complete;
`ifdef WM_DOOR_PAUSE_EN
      if (paused) begin
        if (door_closed) paused <= 1'b0;
      end else if (active && !door_closed) begin
        paused <= 1'b1;
      end
`endif
      if (!hold) begin
        if (in_phase && phase_cnt != CNT_MAX) phase_cnt <= phase_cnt + 1'b1;
        case (st)
          ST_IDLE:  if (start && door_closed) begin st <= ST_FILL;  phase_cnt <= '0; end
          ST_FILL:  if (water_level)          begin st <= ST_WASH;  phase_cnt <= '0; end
          ST_WASH:  if (adv)                  begin st <= ST_RINSE; phase_cnt <= '0; end
          ST_RINSE: if (adv)                  begin st <= ST_SPIN;  phase_cnt <= '0; end
          ST_SPIN:  if (adv)                  begin st <= ST_DRAIN; phase_cnt <= '0; end
          ST_DRAIN: if (adv)                  begin st <= ST_END;   phase_cnt <= '0; end
          ST_END:   if (!door_closed)         begin st <= ST_IDLE;  phase_cnt <= '0; end
          default:                            begin st <= ST_IDLE;  phase_cnt <= '0; end
        endcase
      end
    end
  end

  assign state = st;

  always_comb begin
    motor_on    = 1'b0;
    water_valve = 1'b0;
    drain_valve = 1'b0;
    buzzer      = 1'b0;
    case (st)
      ST_FILL:  water_valve = 1'b1;
      ST_WASH:  motor_on    = 1'b1;
      ST_RINSE: begin motor_on = 1'b1; water_valve = 1'b1; end
      ST_SPIN:  begin motor_on = 1'b1; drain_valve = 1'b1; end
      ST_DRAIN: drain_valve = 1'b1;
      ST_END:   buzzer      = 1'b1;
      default:  ;
    endcase
`ifdef WM_DOOR_PAUSE_EN
    if (paused) begin
      motor_on    = 1'b0;
      water_valve = 1'b0;
      drain_valve = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_washing_machine.sv
// Scoreboard bench for washing_machine: stimulus pushes expected {state,motor,water,drain,buzzer}
// per cycle; a monitor pops and compares after each rising edge.
module tb_washing_machine;

  localparam logic [6:0] E_IDLE  = 7'b000_0000;
  localparam logic [6:0] E_FILL  = 7'b001_0100;
  localparam logic [6:0] E_WASH  = 7'b010_1000;
  localparam logic [6:0] E_RINSE = 7'b011_1100;
  localparam logic [6:0] E_SPIN  = 7'b100_1010;
  localparam logic [6:0] E_DRAIN = 7'b101_0010;
  localparam logic [6:0] E_END   = 7'b110_0001;
  localparam logic [6:0] E_SPINP = 7'b100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, start_a = 1'b0, door_a = 1'b0, wl_a = 1'b0, cc_a = 1'b0;
  logic rst_b = 1'b0, start_b = 1'b0, door_b = 1'b0, wl_b = 1'b0, cc_b = 1'b0;
  logic [2:0] state_a, state_b;
  logic motor_a, water_a, drain_a, buzz_a;
  logic motor_b, water_b, drain_b, buzz_b;

  washing_machine u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .door_closed(door_a),
    .water_level(wl_a), .cycle_complete(cc_a), .state(state_a),
    .motor_on(motor_a), .water_valve(water_a), .drain_valve(drain_a), .buzzer(buzz_a)
  );

  washing_machine #(.MIN_PHASE_CYCLES(4)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .door_closed(door_b),
    .water_level(wl_b), .cycle_complete(cc_b), .state(state_b),
    .motor_on(motor_b), .water_valve(water_b), .drain_valve(drain_b), .buzzer(buzz_b)
  );

  typedef struct {
    logic [6:0] ea;
    bit         ca;
    logic [6:0] eb;
    bit         cb;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;
  bit   stim_done = 1'b0;

  task automatic tick_a(input logic r, input logic s, input logic d, input logic w,
                        input logic c, input logic [6:0] e);
    exp_t x;
    @(negedge clk);
    rst_a = r; start_a = s; door_a = d; wl_a = w; cc_a = c;
    step_no++;
    x.ea = e; x.ca = 1'b1; x.eb = '0; x.cb = 1'b0; x.step = step_no;
    exp_q.push_back(x);
  endtask

  task automatic tick_b(input logic r, input logic s, input logic d, input logic w,
                        input logic c, input logic [6:0] e);
    exp_t x;
    @(negedge clk);
    rst_b = r; start_b = s; door_b = d; wl_b = w; cc_b = c;
    step_no++;
    x.ea = '0; x.ca = 1'b0; x.eb = e; x.cb = 1'b1; x.step = step_no;
    exp_q.push_back(x);
  endtask

  // Monitor: sample 2 time units after each rising edge.
  always @(posedge clk) begin
    exp_t x;
    logic [6:0] got;
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.ca) begin
        got = {state_a, motor_a, water_a, drain_a, buzz_a};
        checks++;
        if (got !== x.ea) begin
          errors++;
          $display("FAIL dut_a step %0d: got %b expected %b", x.step, got, x.ea);
        end
      end
      if (x.cb) begin
        got = {state_b, motor_b, water_b, drain_b, buzz_b};
        checks++;
        if (got !== x.eb) begin
          errors++;
          $display("FAIL dut_b_min4 step %0d: got %b expected %b", x.step, got, x.eb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus_done=%0d expected 1", stim_done);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with start and door asserted, then a full program.
    tick_a(0, 1, 1, 0, 0, E_IDLE);
    tick_a(1, 1, 1, 0, 0, E_FILL);
    tick_a(1, 0, 1, 0, 0, E_FILL);
    tick_a(1, 0, 1, 1, 1, E_WASH);   // water_level and cc edge together: WASH only
    tick_a(1, 0, 1, 1, 0, E_WASH);
    tick_a(1, 0, 1, 1, 1, E_RINSE);
    tick_a(1, 0, 1, 1, 0, E_RINSE);
    tick_a(1, 0, 1, 1, 1, E_SPIN);
    tick_a(1, 0, 1, 1, 0, E_SPIN);
    tick_a(1, 0, 1, 1, 1, E_DRAIN);
    tick_a(1, 0, 1, 1, 0, E_DRAIN);
    tick_a(1, 0, 1, 1, 1, E_END);
    tick_a(1, 0, 1, 1, 0, E_END);
    tick_a(1, 1, 1, 0, 0, E_END);    // start ignored in END while door closed
    // Door opened in END, start still high.
    tick_a(1, 1, 0, 0, 0, E_IDLE);
    tick_a(1, 1, 0, 0, 0, E_IDLE);
    tick_a(1, 1, 1, 0, 0, E_FILL);
    tick_a(1, 0, 1, 1, 0, E_WASH);
    // cycle_complete held high 5 cycles: one advance only.
    for (int i = 0; i < 5; i++) tick_a(1, 0, 1, 1, 1, E_RINSE);
    tick_a(1, 0, 1, 1, 0, E_RINSE);
    tick_a(1, 0, 1, 1, 1, E_SPIN);
    tick_a(1, 0, 1, 1, 0, E_SPIN);
    // Reset in SPIN overrides a coincident cc edge.
    tick_a(0, 1, 1, 1, 1, E_IDLE);
    tick_a(1, 0, 1, 0, 0, E_IDLE);
    // start with door open stays IDLE.
    for (int i = 0; i < 4; i++) tick_a(1, 1, 0, 0, 0, E_IDLE);
    // Door opened during SPIN.
    tick_a(1, 1, 1, 0, 0, E_FILL);
    tick_a(1, 0, 1, 1, 0, E_WASH);
    tick_a(1, 0, 1, 1, 1, E_RINSE);
    tick_a(1, 0, 1, 1, 0, E_RINSE);
    tick_a(1, 0, 1, 1, 1, E_SPIN);
    tick_a(1, 0, 1, 1, 0, E_SPIN);
`ifdef WM_DOOR_PAUSE_EN
    tick_a(1, 0, 0, 1, 0, E_SPINP);
    tick_a(1, 0, 0, 1, 1, E_SPINP);  // cc edge ignored while paused
    tick_a(1, 0, 1, 1, 0, E_SPIN);
    tick_a(1, 0, 1, 1, 1, E_DRAIN);
`else
    tick_a(1, 0, 0, 1, 0, E_SPIN);
    tick_a(1, 0, 0, 1, 1, E_DRAIN);
    tick_a(1, 0, 1, 1, 0, E_DRAIN);
    tick_a(1, 0, 1, 1, 1, E_END);
`endif
    tick_a(0, 0, 1, 0, 0, E_IDLE);

    // Minimum phase length of 4 on the second instance.
    tick_b(0, 0, 1, 0, 0, E_IDLE);
    tick_b(1, 1, 1, 0, 0, E_FILL);
    tick_b(1, 0, 1, 1, 0, E_WASH);
    tick_b(1, 0, 1, 1, 0, E_WASH);
    tick_b(1, 0, 1, 1, 1, E_WASH);   // count 1, too early: dropped
    tick_b(1, 0, 1, 1, 0, E_WASH);
    tick_b(1, 0, 1, 1, 0, E_WASH);
    tick_b(1, 0, 1, 1, 1, E_RINSE);  // count 4: honoured
    tick_b(1, 0, 1, 1, 0, E_RINSE);
    tick_b(1, 0, 1, 1, 1, E_RINSE);
    tick_b(1, 0, 1, 1, 0, E_RINSE);
    tick_b(1, 0, 1, 1, 0, E_RINSE);
    tick_b(1, 0, 1, 1, 0, E_RINSE);
    tick_b(1, 0, 1, 1, 1, E_SPIN);

    stim_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: pending %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
